memory_stage: RTL and testbench

//  MEM stage of the RV32I 5-stage pipeline. Sits directly downstream of the EX/MEM register.

---
 rtl/memory_stage.sv | 205 ++++++++++++++++++++
 tb/tb_memory_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I MEM stage: byte-lane data RAM access with wait states and load extension
//
// Purpose:
//   Sits after the EX/MEM register. Performs loads and stores on a word-organised
//   data RAM, holds the pipeline (StallM) while an access is in flight and presents
//   the sign/zero-extended load result to the MEM/WB register.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : MisalignM port exists; misaligned requests are suppressed and flagged.
//   undefined : no MisalignM port; misaligned addresses are silently aligned.
//
// Ports:
//   clk         in   1   clock
//   rst         in   1   synchronous active-high reset
//   ALUResultM  in   32  byte address
//   WriteDataM  in   32  store data
//   MemWriteM   in   1   store request (wins over a load request)
//   ResultSrcM  in   2   2'b01 = load request
//   Funct3M     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (others act as W)
//   ReadDataM   out  32  extended load data, valid while the FSM is in DONE
//   StallM      out  1   freeze EX/MEM and earlier stages
//   MisalignM   out  1   misaligned request flag (MISALIGN_TRAP_EN only)

module memory_stage #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        MisalignM
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic is_store;
  logic is_load;
  logic req;
  logic size_b;
  logic size_h;
  logic size_w;
  logic ld_unsigned;
  logic trap;
  logic [1:0] lo;
  logic [4:0] n_cost;

  assign is_store    = MemWriteM;
  assign is_load     = ~MemWriteM & (ResultSrcM == 2'b01);
  assign req         = is_store | is_load;
  assign size_b      = (Funct3M == 3'b000) | (Funct3M == 3'b100);
  assign size_h      = (Funct3M == 3'b001) | (Funct3M == 3'b101);
  assign size_w      = ~size_b & ~size_h;
  assign ld_unsigned = Funct3M[2];

  // A store needs WAIT_STATES cycles; a load needs one more to capture the data.
  assign n_cost = is_store ? 5'(WAIT_STATES) : 5'(WAIT_STATES + 1);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (size_h & ALUResultM[0]) | (size_w & (ALUResultM[1:0] != 2'b00));
  assign trap       = req & misaligned;
  assign lo         = ALUResultM[1:0];
  assign MisalignM  = ~rst & trap;
`else
  assign trap = 1'b0;
  // Misaligned halfword/word accesses drop the offending low address bits.
  assign lo   = size_w ? 2'b00 : (size_h ? {ALUResultM[1], 1'b0} : ALUResultM[1:0]);
`endif

  // Address bits above the RAM size are ignored so accesses wrap.
  logic [AW-1:0] wi;
  logic          unused_addr;
  assign wi          = ALUResultM[AW+1:2];
  assign unused_addr = ^ALUResultM;

  // ---------------------------------------------------------------------------
  // Access timing
  // ---------------------------------------------------------------------------
  logic idle_go;
  logic access;

  assign idle_go = (state_q == IDLE) & req & ~trap;
  // The RAM edge is either straight out of IDLE (cost 0 or 1) or the last BUSY cycle.
  // rst blocks it so a pending store is dropped without touching the RAM.
  assign access  = ~rst & ((idle_go & (n_cost <= 5'd1)) | ((state_q == BUSY) & (cnt_q == 4'd0)));
  assign StallM  = ~rst & ((idle_go & (n_cost != 5'd0)) | (state_q == BUSY));

  // ---------------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------------
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        we;

  always_comb begin
    be    = 4'b1111;
    wdata = WriteDataM;
    if (size_b) begin
      be    = 4'b0001 << lo;
      wdata = {4{WriteDataM[7:0]}};
    end else if (size_h) begin
      be    = lo[1] ? 4'b1100 : 4'b0011;
      wdata = {2{WriteDataM[15:0]}};
    end
  end

  assign we = access & is_store;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[wi][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane select and extension
  // ---------------------------------------------------------------------------
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_ext;

  assign rword = mem_q[wi];
  assign rbyte = rword[{lo, 3'b000} +: 8];
  assign rhalf = lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld_ext = rword;
    if (size_b) begin
      ld_ext = ld_unsigned ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
    end else if (size_h) begin
      ld_ext = ld_unsigned ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req & trap) begin
            rdata_q <= 32'd0;
          end else if (req) begin
            if (n_cost == 5'd1) begin
              state_q <= DONE;
            end else if (n_cost > 5'd1) begin
              cnt_q   <= 4'(n_cost - 5'd2);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // The held instruction leaves the stage on this edge; never re-arm on it.
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (access & ~is_store) begin
        rdata_q <= ld_ext;
      end
    end
  end

  assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed scoreboard bench for memory_stage (WAIT_STATES 2 and 0 instances)

module tb_memory_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WAIT_STATES=2
  logic [31:0] a_addr = '0, a_wd = '0;
  logic        a_we = 1'b0;
  logic [1:0]  a_rs = '0;
  logic [2:0]  a_f3 = '0;
  logic [31:0] a_rd;
  logic        a_stall;
  // Instance B: WAIT_STATES=0
  logic [31:0] b_addr = '0, b_wd = '0;
  logic        b_we = 1'b0;
  logic [1:0]  b_rs = '0;
  logic [2:0]  b_f3 = '0;
  logic [31:0] b_rd;
  logic        b_stall;
`ifdef MISALIGN_TRAP_EN
  logic        a_mis, b_mis;
`endif

  memory_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst(rst), .ALUResultM(a_addr), .WriteDataM(a_wd), .MemWriteM(a_we),
    .ResultSrcM(a_rs), .Funct3M(a_f3), .ReadDataM(a_rd), .StallM(a_stall)
`ifdef MISALIGN_TRAP_EN
    , .MisalignM(a_mis)
`endif
  );

  memory_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst), .ALUResultM(b_addr), .WriteDataM(b_wd), .MemWriteM(b_we),
    .ResultSrcM(b_rs), .Funct3M(b_f3), .ReadDataM(b_rd), .StallM(b_stall)
`ifdef MISALIGN_TRAP_EN
    , .MisalignM(b_mis)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_q[$];

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drives one instance and parks the other idle so it cannot re-trigger.
  task automatic drive(input bit inst_b, input bit wr, input bit ld, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    a_we = 1'b0; a_rs = 2'b00; b_we = 1'b0; b_rs = 2'b00;
    if (inst_b) begin
      b_we = wr; b_rs = ld ? 2'b01 : 2'b00; b_f3 = f3; b_addr = addr; b_wd = wd;
    end else begin
      a_we = wr; a_rs = ld ? 2'b01 : 2'b00; a_f3 = f3; a_addr = addr; a_wd = wd;
    end
  endtask

  function automatic logic cur_stall(input bit inst_b);
    return inst_b ? b_stall : a_stall;
  endfunction

  function automatic logic [31:0] cur_rd(input bit inst_b);
    return inst_b ? b_rd : a_rd;
  endfunction

  // One memory instruction: count stall cycles, then in the first unstalled cycle
  // pop the expected load value and compare it with ReadDataM.
  task automatic run_op(input string tag, input bit inst_b, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_stall, input logic [31:0] exp_rd);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    drive(inst_b, wr, ~wr, f3, addr, wd);
    if (!wr) sb_q.push_back(exp_rd);
    n = 0;
    #1;
    while (cur_stall(inst_b) === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    check32({tag, "_stall"}, 32'(n), 32'(exp_stall));
    if (!wr) begin
      exp = sb_q.pop_front();
      check32({tag, "_rd"}, cur_rd(inst_b), exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check32("rst_stall_a", 32'(a_stall), 32'd0);
    check32("rst_rd_a", a_rd, 32'd0);
    check32("rst_stall_b", 32'(b_stall), 32'd0);
    check32("rst_rd_b", b_rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // WAIT_STATES=2: store costs 2, load costs 3
    run_op("sw_10",  0, 1, F_W,  32'h10, 32'hDEADBEEF, 2, 32'h0);
    run_op("lw_10",  0, 0, F_W,  32'h10, 32'h0, 3, 32'hDEADBEEF);
    run_op("sb_13",  0, 1, F_B,  32'h13, 32'h12345680, 2, 32'h0);
    run_op("lb_13",  0, 0, F_B,  32'h13, 32'h0, 3, 32'hFFFFFF80);
    run_op("lbu_13", 0, 0, F_BU, 32'h13, 32'h0, 3, 32'h00000080);
    run_op("lw_10b", 0, 0, F_W,  32'h10, 32'h0, 3, 32'h80ADBEEF);
    run_op("sh_12",  0, 1, F_H,  32'h12, 32'hABCD8001, 2, 32'h0);
    run_op("lhu_12", 0, 0, F_HU, 32'h12, 32'h0, 3, 32'h00008001);
    run_op("lh_12",  0, 0, F_H,  32'h12, 32'h0, 3, 32'hFFFF8001);
    run_op("lw_10c", 0, 0, F_W,  32'h10, 32'h0, 3, 32'h8001BEEF);
    run_op("lb_10",  0, 0, F_B,  32'h10, 32'h0, 3, 32'hFFFFFFEF);
    run_op("lbu_11", 0, 0, F_BU, 32'h11, 32'h0, 3, 32'h000000BE);
    run_op("f3_011", 0, 0, 3'b011, 32'h10, 32'h0, 3, 32'h8001BEEF);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    drive(0, 0, 1, F_H, 32'h11, 32'h0);
    #1;
    check32("trap_mis", 32'(a_mis), 32'd1);
    check32("trap_stall", 32'(a_stall), 32'd0);
    @(negedge clk);
    #1;
    check32("trap_rd", a_rd, 32'd0);
`else
    run_op("lh_11_align", 0, 0, F_H, 32'h11, 32'h0, 3, 32'hFFFFBEEF);
    run_op("lw_12_align", 0, 0, F_W, 32'h12, 32'h0, 3, 32'h8001BEEF);
`endif

    // Address wrap: 0x1000 aliases word 0
    run_op("sw_wrap", 0, 1, F_W, 32'h1000, 32'hCAFEF00D, 2, 32'h0);
    run_op("lw_wrap", 0, 0, F_W, 32'h0, 32'h0, 3, 32'hCAFEF00D);

    // Reset while a store sits in BUSY: store is dropped
    run_op("sw_20_old", 0, 1, F_W, 32'h20, 32'h11112222, 2, 32'h0);
    run_op("lw_20_old", 0, 0, F_W, 32'h20, 32'h0, 3, 32'h11112222);
    @(negedge clk);
    drive(0, 1, 0, F_W, 32'h20, 32'h12345678);
    #1;
    check32("rstbusy_stall_idle", 32'(a_stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, F_W, 32'h0, 32'h0);
    #1;
    check32("rstbusy_stall_after", 32'(a_stall), 32'd0);
    check32("rstbusy_rd_after", a_rd, 32'd0);
    run_op("lw_20_kept", 0, 0, F_W, 32'h20, 32'h0, 3, 32'h11112222);

    // WAIT_STATES=0: stores never stall, loads stall exactly one cycle
    run_op("b_sw_0",  1, 1, F_W,  32'h0, 32'h55AA33CC, 0, 32'h0);
    run_op("b_lw_0",  1, 0, F_W,  32'h0, 32'h0, 1, 32'h55AA33CC);
    run_op("b_sw_4",  1, 1, F_W,  32'h4, 32'h01020304, 0, 32'h0);
    run_op("b_lw_0b", 1, 0, F_W,  32'h0, 32'h0, 1, 32'h55AA33CC);
    run_op("b_lw_4",  1, 0, F_W,  32'h4, 32'h0, 1, 32'h01020304);
    run_op("b_sb_5",  1, 1, F_B,  32'h5, 32'h000000FF, 0, 32'h0);
    run_op("b_lhu_4", 1, 0, F_HU, 32'h4, 32'h0, 1, 32'h0000FF04);
    run_op("b_lh_6",  1, 0, F_H,  32'h6, 32'h0, 1, 32'h00000102);
    run_op("b_lb_5",  1, 0, F_B,  32'h5, 32'h0, 1, 32'hFFFFFFFF);

    @(negedge clk);
    drive(0, 0, 0, F_W, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
